bicubic_wmatrix_sched: RTL and testbench
========================================

# bicubic_wmatrix_sched

Sequencer for a shared 4x4 weight-matrix × pixel-vector datapath (four parallel 4-tap inner-product units with a common pixel vector) that performs separable bicubic interpolation on one 4x4 source window. The block runs a horizontal pass (4 rows) and then a vertical pass (4 intermediate columns) through the datapath. It buffers the intermediates, clamps the results to pixels and emits a 4x4 output patch as four row beats. It sits between the window-fetch stage and the output-pixel packer. The datapath is instantiated outside this block and connected through the `dp_*` ports.

## Interface

Parameters:
- PIXEL_WIDTH, 8, source/output pixel width
- PRODUCT_WIDTH, 32, datapath pixel-input width; result magnitude is PRODUCT_WIDTH-1
- SHIFT, 8, right shift applied to final magnitude (two passes of 1/16 weights)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  source window valid
- in_ready  out  1  block can accept a window
- in_window  in  16*PIXEL_WIDTH  pixel (r,j) at bits [(4r+j)*PIXEL_WIDTH +: PIXEL_WIDTH], r,j in 0..3
- h_weights  in  64  horizontal weights; w(k,j) at bits [(4k+j)*4 +: 4]; output column k, tap j
- v_weights  in  64  vertical weights, same packing; output row k, tap j
- out_valid  out  1  output row beat valid
- out_ready  in  1  downstream accepts beat
- out_row  out  4*PIXEL_WIDTH  one output row; column c at bits [c*PIXEL_WIDTH +: PIXEL_WIDTH]
- dp_w  out  64  weights to datapath; unit k tap j at bits [(4k+j)*4 +: 4]
- dp_p  out  4*PRODUCT_WIDTH  pixel vector; tap j at bits [j*PRODUCT_WIDTH +: PRODUCT_WIDTH]
- dp_mag  in  4*(PRODUCT_WIDTH-1)  inner-product magnitude of unit k
- dp_sign  in  4  inner-product sign of unit k (1 = negative)

## Operation

- States: IDLE, HPASS, VPASS, OUT. A 2-bit index idx is used in every non-IDLE state.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_window, h_weights and v_weights into local registers; idx←0; go to HPASS.
  - The captured weights stay fixed for the whole window.
- HPASS, row r=idx:
  - dp_w = captured h_weights.
  - dp_p tap j = source pixel (r,j), zero-extended to PRODUCT_WIDTH, so its sign bit is 0.
  - Each cycle, for each unit k: ibuf[r][k] ← {dp_sign[k], dp_mag[k]}.
  - idx==3 → idx←0, go to VPASS; else idx++.
- VPASS, intermediate column c=idx:
  - dp_w = captured v_weights.
  - dp_p tap j = ibuf[j][c], PRODUCT_WIDTH bits, sign in MSB.
  - Each cycle: obuf[k][c] ← clamp(dp_sign[k], dp_mag[k]).
  - idx==3 → idx←0, go to OUT; else idx++.
- clamp(sign, mag): if sign=1 → 0; else m = mag>>SHIFT; if m > 2^PIXEL_WIDTH−1 → 2^PIXEL_WIDTH−1, else m.
- OUT:
  - out_valid=1; out_row = obuf[idx][0..3].
  - On out_ready: idx==3 → go to IDLE; else idx++.
  - While out_ready=0, out_row and out_valid hold stable.
- The datapath is combinational; results are registered in the same cycle as the inputs are driven.
- In IDLE and OUT: dp_w=0 and dp_p=0.
- Reset:
  - Any state → IDLE, idx=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_row=0, dp_w=0, dp_p=0.
  - obuf and ibuf are cleared to 0.
- Reset mid-window discards the window; no partial rows are emitted.
- in_window changes outside the acceptance cycle have no effect.

## Timing

- Window accepted at edge E0. HPASS occupies the 4 cycles after E0, then VPASS the next 4.
- First out_valid is asserted in the cycle after E0+8.
- Full-rate drain with out_ready=1:
  - Rows 0..3 occupy cycles 9..12 after acceptance.
  - in_ready=1 at cycle 13.
- Minimum window period is 13 cycles.
- in_ready=0 from the cycle after acceptance until OUT completes.
- Input and output never handshake in the same cycle.
- out_valid never deasserts without a handshake, except on rst.

## Test plan

- The bench uses a datapath model: mag_k = Σ_j w(k,j)·p_j unsigned, sign_k = 0 (a later test forces sign).
- Uniform window: all pixels 100, all weights 4 → H intermediates 1600, V sums 25600, >>8 → four beats each of four pixels 100. out_valid cycles 9..12 after acceptance; in_ready back at cycle 13.
- Saturation: all pixels 255, all weights 15 → V sum 918000>>8 = 3585 → every output pixel 255.
- Negative clamp: model forces dp_sign=4'b1111 during VPASS → all outputs 0. Forcing sign during HPASS only must appear as MSB=1 on dp_p in VPASS.
- Back-pressure: out_ready low for 3 cycles on row 1 → out_row and out_valid stable; rows arrive in order 0,1,2,3 with no duplicates; in_valid held high is not accepted until after row 3.
- Reset mid-operation: rst during VPASS cycle 1 → next cycle in_ready=1, out_valid=0, dp_w=0, dp_p=0. A new uniform-100 window then completes correctly.
- Index/packing check: pixel (r,j)=16r+j, weights one-hot (w(k,k)=15, others 0) → output pixel (k,c) = clamp(225·(16k+c)>>8). Each value lands at row k, column c.

Source files
------------

// File: rtl/bicubic_wmatrix_sched.sv
// rtl/bicubic_wmatrix_sched.sv - sequencer for separable bicubic 4x4 interpolation on a shared weight-matrix datapath
//
// Purpose: accepts one 4x4 source window and its horizontal/vertical weight
// sets, drives an external 4-unit inner-product datapath through a
// horizontal pass (4 rows) and a vertical pass (4 intermediate columns),
// clamps the vertical results to pixels and emits the 4x4 patch as four row
// beats.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   source window handshake; in_window, h_weights, v_weights
//   out_valid/ready  output row handshake; out_row holds one output row
//   dp_w, dp_p       weights and pixel vector driven to the datapath
//   dp_mag, dp_sign  per-unit inner-product magnitude and sign from the datapath
module bicubic_wmatrix_sched #(
  parameter int PIXEL_WIDTH   = 8,
  parameter int PRODUCT_WIDTH = 32,
  parameter int SHIFT         = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [16*PIXEL_WIDTH-1:0]      in_window,
  input  logic [63:0]                    h_weights,
  input  logic [63:0]                    v_weights,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [4*PIXEL_WIDTH-1:0]       out_row,
  output logic [63:0]                    dp_w,
  output logic [4*PRODUCT_WIDTH-1:0]     dp_p,
  input  logic [4*(PRODUCT_WIDTH-1)-1:0] dp_mag,
  input  logic [3:0]                     dp_sign
);

  localparam int MW = PRODUCT_WIDTH - 1;
  localparam logic [MW-1:0] PIX_MAX = {{(MW-PIXEL_WIDTH){1'b0}}, {PIXEL_WIDTH{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_HPASS, S_VPASS, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic [16*PIXEL_WIDTH-1:0] win_q;
  logic [63:0]              hw_q;
  logic [63:0]              vw_q;
  // ibuf_q[row][col]: signed-magnitude intermediates, sign in MSB
  logic [PRODUCT_WIDTH-1:0] ibuf_q [4][4];
  // obuf_q[row][col]: final clamped pixels
  logic [PIXEL_WIDTH-1:0]   obuf_q [4][4];

  function automatic logic [PIXEL_WIDTH-1:0] clamp_pix(input logic sign, input logic [MW-1:0] mag);
    logic [MW-1:0] m;
    m = mag >> SHIFT;
    if (sign)
      return '0;
    else if (m > PIX_MAX)
      return {PIXEL_WIDTH{1'b1}};
    else
      return m[PIXEL_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_row   = '0;
    dp_w      = '0;
    dp_p      = '0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = S_HPASS;
          idx_d   = 2'd0;
        end
      end
      S_HPASS: begin
        dp_w = hw_q;
        for (int j = 0; j < 4; j++) begin
          dp_p[j*PRODUCT_WIDTH +: PRODUCT_WIDTH] =
            {{(PRODUCT_WIDTH-PIXEL_WIDTH){1'b0}}, win_q[(4*int'(idx_q)+j)*PIXEL_WIDTH +: PIXEL_WIDTH]};
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_VPASS;
      end
      S_VPASS: begin
        dp_w = vw_q;
        // Tap j of the vertical pass is intermediate row j of column idx.
        for (int j = 0; j < 4; j++) begin
          dp_p[j*PRODUCT_WIDTH +: PRODUCT_WIDTH] = ibuf_q[j][idx_q];
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
          out_row[c*PIXEL_WIDTH +: PIXEL_WIDTH] = obuf_q[idx_q][c];
        end
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      win_q   <= '0;
      hw_q    <= '0;
      vw_q    <= '0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          ibuf_q[r][c] <= '0;
          obuf_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == S_IDLE && in_valid) begin
        win_q <= in_window;
        hw_q  <= h_weights;
        vw_q  <= v_weights;
      end
      if (state_q == S_HPASS) begin
        for (int k = 0; k < 4; k++) begin
          ibuf_q[idx_q][k] <= {dp_sign[k], dp_mag[k*MW +: MW]};
        end
      end
      if (state_q == S_VPASS) begin
        for (int k = 0; k < 4; k++) begin
          obuf_q[k][idx_q] <= clamp_pix(dp_sign[k], dp_mag[k*MW +: MW]);
        end
      end
    end
  end

endmodule

// File: tb/tb_bicubic_wmatrix_sched.sv
// tb/tb_bicubic_wmatrix_sched.sv - self-checking bench for bicubic_wmatrix_sched
module tb_bicubic_wmatrix_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_window;
  logic [63:0]  h_weights;
  logic [63:0]  v_weights;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_row;
  logic [63:0]  dp_w;
  logic [127:0] dp_p;
  logic [123:0] dp_mag;
  logic [3:0]   dp_sign;

  logic         force_sign;
  logic [31:0]  acc;
  logic [127:0] win;
  logic [63:0]  hw;
  logic [63:0]  vw;
  logic [31:0]  exp_q [$];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  bicubic_wmatrix_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_window (in_window),
    .h_weights (h_weights),
    .v_weights (v_weights),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .dp_w      (dp_w),
    .dp_p      (dp_p),
    .dp_mag    (dp_mag),
    .dp_sign   (dp_sign)
  );

  // Datapath model: unsigned inner product on the magnitude bits, forced sign.
  always_comb begin
    dp_mag = '0;
    acc    = '0;
    for (int k = 0; k < 4; k++) begin
      acc = '0;
      for (int j = 0; j < 4; j++) begin
        acc = acc + 32'(dp_w[(4*k+j)*4 +: 4]) * 32'(dp_p[j*32 +: 31]);
      end
      dp_mag[k*31 +: 31] = acc[30:0];
    end
    dp_sign = {4{force_sign}};
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill(input int mode, input int pv, input int wv);
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        win[(4*r+j)*8 +: 8] = (mode == 1) ? 8'(16*r + j) : 8'(pv);
        hw[(4*r+j)*4 +: 4]  = (mode == 1) ? ((r == j) ? 4'd15 : 4'd0) : 4'(wv);
        vw[(4*r+j)*4 +: 4]  = (mode == 1) ? ((r == j) ? 4'd15 : 4'd0) : 4'(wv);
      end
    end
  endtask

  task automatic push_expected(input bit fv);
    int inter [4][4];
    int s;
    int m;
    logic [31:0] row;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        inter[r][k] = 0;
        for (int j = 0; j < 4; j++)
          inter[r][k] += int'(hw[(4*k+j)*4 +: 4]) * int'(win[(4*r+j)*8 +: 8]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      row = '0;
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int j = 0; j < 4; j++)
          s += int'(vw[(4*k+j)*4 +: 4]) * inter[j][c];
        m = s >> 8;
        if (fv) m = 0;
        else if (m > 255) m = 255;
        row[c*8 +: 8] = m[7:0];
      end
      exp_q.push_back(row);
    end
  endtask

  // Called just after a negedge with the block idle.
  task automatic run_window(input bit fh, input bit fv, input int stall_row,
                            input int stall_n, input bit hold_valid);
    in_window = win;
    h_weights = hw;
    v_weights = vw;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk("in_ready_accept", 128'(in_ready), 128'(1));
    push_expected(fv);
    step();
    if (!hold_valid) in_valid = 1'b0;
    in_window = ~win;
    h_weights = ~hw;
    v_weights = ~vw;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      force_sign = (cyc <= 4) ? fh : fv;
      chk("in_ready_busy", 128'(in_ready), 128'(0));
      chk("out_valid_early", 128'(out_valid), 128'(0));
      if (fh && cyc >= 5)
        chk("vpass_sign_msb", 128'({dp_p[127], dp_p[95], dp_p[63], dp_p[31]}), 128'(4'hf));
      step();
    end
    force_sign = 1'b0;
    for (int row = 0; row < 4; row++) begin
      if (row == stall_row) begin
        for (int s = 0; s < stall_n; s++) begin
          out_ready = 1'b0;
          chk("stall_valid", 128'(out_valid), 128'(1));
          chk("stall_row_hold", 128'(out_row), 128'(exp_q.size() > 0 ? exp_q[0] : 32'hx));
          chk("stall_in_ready", 128'(in_ready), 128'(0));
          step();
        end
      end
      out_ready = 1'b1;
      chk("out_valid_beat", 128'(out_valid), 128'(1));
      chk("in_ready_during_out", 128'(in_ready), 128'(0));
      if (out_valid && exp_q.size() > 0)
        chk("out_row", 128'(out_row), 128'(exp_q.pop_front()));
      step();
    end
    chk("in_ready_after", 128'(in_ready), 128'(1));
    chk("out_valid_after", 128'(out_valid), 128'(0));
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    force_sign = 1'b0;
    in_window  = '0;
    h_weights  = '0;
    v_weights  = '0;
    win = '0; hw = '0; vw = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_row", 128'(out_row), 128'(0));
    chk("rst_dp_w", 128'(dp_w), 128'(0));
    chk("rst_dp_p", 128'(dp_p), 128'(0));
    rst = 1'b0;
    step();

    // Uniform window: every output pixel 100
    fill(0, 100, 4);
    chk("model_uniform", 128'(32'h64646464), 128'(32'h64646464) ^ 128'(win[31:0]) ^ 128'(32'h64646464));
    run_window(1'b0, 1'b0, -1, 0, 1'b0);

    // Saturation
    fill(0, 255, 15);
    run_window(1'b0, 1'b0, -1, 0, 1'b0);

    // Negative clamp in VPASS
    fill(0, 100, 4);
    run_window(1'b0, 1'b1, -1, 0, 1'b0);

    // Sign forced in HPASS only shows as MSB on VPASS taps
    run_window(1'b1, 1'b0, -1, 0, 1'b0);

    // Back-pressure on row 1 with in_valid held high, then index/packing window
    fill(0, 100, 4);
    run_window(1'b0, 1'b0, 1, 3, 1'b1);
    fill(1, 0, 0);
    run_window(1'b0, 1'b0, -1, 0, 1'b0);

    // Reset during VPASS
    fill(0, 77, 9);
    in_window = win; h_weights = hw; v_weights = vw;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_out_row", 128'(out_row), 128'(0));
    chk("midrst_dp_w", 128'(dp_w), 128'(0));
    chk("midrst_dp_p", 128'(dp_p), 128'(0));
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("midrst_no_partial", 128'(out_valid), 128'(0));
      step();
    end
    fill(0, 100, 4);
    run_window(1'b0, 1'b0, -1, 0, 1'b0);

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
